// File: rtl/shifter_seq_if.sv
// Control/data bundle for shifter_seq: requests and burst setup in, register state and handshake out.
interface shifter_seq_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             enable;
    logic             sclr;
    logic             sset;
    logic             load;
    logic [WIDTH-1:0] data;
    logic             shift;
    logic             start;
    logic [CNT_W-1:0] count;
    logic             dir;
    logic [1:0]       mode;
    logic             shiftin;
    logic [WIDTH-1:0] q;
    logic             shiftout;
    logic             busy;
    logic             done;

    modport master (
        output enable, sclr, sset, load, data, shift, start, count, dir, mode, shiftin,
        input  q, shiftout, busy, done
    );

    modport slave (
        input  enable, sclr, sset, load, data, shift, start, count, dir, mode, shiftin,
        output q, shiftout, busy, done
    );
endinterface

// File: rtl/shifter_seq.sv
// Sequencing shift register: logical/rotate/arithmetic single-bit shifts, either one
// per request or as a counted burst with busy/done handshake.
module shifter_seq #(
    parameter int               WIDTH       = 8,
    parameter int               CNT_W       = 4,
    parameter logic [WIDTH-1:0] LOAD_AVALUE = {{(WIDTH-1){1'b0}}, 1'b1},
    parameter logic [WIDTH-1:0] LOAD_SVALUE = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic          clock,
    input  logic          aclr,
    input  logic          aset,
    shifter_seq_if.slave  bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             so_q, so_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] step_q;
    logic             step_so;

    // One shift step from the current register, steered by the live dir/mode/shiftin.
    always_comb begin
        step_q  = q_q;
        step_so = so_q;
        case (bus.mode)
            2'b01: begin
                if (bus.dir) begin
                    step_q  = {q_q[0], q_q[WIDTH-1:1]};
                    step_so = q_q[0];
                end else begin
                    step_q  = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    step_so = q_q[WIDTH-1];
                end
            end
            2'b10: begin
                if (bus.dir) begin
                    step_q  = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
                    step_so = q_q[0];
                end else begin
                    step_q  = {q_q[WIDTH-2:0], 1'b0};
                    step_so = q_q[WIDTH-1];
                end
            end
            default: begin
                if (bus.dir) begin
                    step_q  = {bus.shiftin, q_q[WIDTH-1:1]};
                    step_so = q_q[0];
                end else begin
                    step_q  = {q_q[WIDTH-2:0], bus.shiftin};
                    step_so = q_q[WIDTH-1];
                end
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        so_d    = so_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        if (bus.enable) begin
            if (bus.sclr) begin
                q_d     = '0;
                rem_d   = '0;
                state_d = IDLE;
            end else if (bus.sset) begin
                q_d     = LOAD_SVALUE;
                rem_d   = '0;
                state_d = IDLE;
            end else if (bus.load) begin
                q_d     = bus.data;
                rem_d   = '0;
                state_d = IDLE;
            end else if (state_q == IDLE) begin
                if (bus.start) begin
                    // A zero-length burst completes at once without touching q.
                    if (bus.count != '0) begin
                        rem_d   = bus.count;
                        state_d = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end else if (bus.shift) begin
                    q_d  = step_q;
                    so_d = step_so;
                end
            end else begin
                q_d   = step_q;
                so_d  = step_so;
                rem_d = rem_q - CNT_W'(1);
                if (rem_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge aclr or posedge aset) begin
        if (aclr) begin
            state_q <= IDLE;
            q_q     <= '0;
            so_q    <= 1'b0;
            done_q  <= 1'b0;
            rem_q   <= '0;
        end else if (aset) begin
            state_q <= IDLE;
            q_q     <= LOAD_AVALUE;
            so_q    <= 1'b0;
            done_q  <= 1'b0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            so_q    <= so_d;
            done_q  <= done_d;
            rem_q   <= rem_d;
        end
    end

    assign bus.q        = q_q;
    assign bus.shiftout = so_q;
    assign bus.busy     = (state_q == RUN);
    assign bus.done     = done_q;
endmodule

// File: tb/tb_shifter_seq.sv
// Directed bench for shifter_seq: hand-computed expectations for loads, bursts, stalls and aborts.
module tb_shifter_seq;
    logic clock = 1'b0;
    logic aclr, aset;
    int   n_chk  = 0;
    int   n_fail = 0;

    shifter_seq_if #(.WIDTH(8), .CNT_W(4)) bif ();

    shifter_seq #(.WIDTH(8), .CNT_W(4)) dut (
        .clock (clock),
        .aclr  (aclr),
        .aset  (aset),
        .bus   (bif.slave)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_load(input logic [7:0] v);
        bif.load = 1'b1;
        bif.data = v;
        tick();
        bif.load = 1'b0;
    endtask

    // Issue a burst, optionally stalling enable for len cycles starting at loop step s;
    // returns the number of sampled busy cycles before done appears.
    task automatic burst(input logic [3:0] n, input int s, input int len, output int bc);
        bit seen = 1'b0;
        bif.start = 1'b1;
        bif.count = n;
        tick();
        bif.start = 1'b0;
        bc = 0;
        for (int i = 0; i < 60; i++) begin
            if (bif.done) begin
                seen = 1'b1;
                break;
            end
            if (bif.busy) bc++;
            bif.enable = !(i >= s && i < s + len);
            tick();
        end
        bif.enable = 1'b1;
        if (!seen) chk("burst_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int bc;
        int dcnt;
        aclr = 1'b1; aset = 1'b0;
        bif.enable = 1'b0; bif.sclr = 1'b0; bif.sset = 1'b0; bif.load = 1'b0;
        bif.data = '0; bif.shift = 1'b0; bif.start = 1'b0; bif.count = '0;
        bif.dir = 1'b0; bif.mode = 2'b00; bif.shiftin = 1'b0;
        tick(); tick();
        chk("rst_q", 32'(bif.q), 32'h00);
        chk("rst_busy", 32'(bif.busy), 32'd0);
        chk("rst_done", 32'(bif.done), 32'd0);
        chk("rst_so", 32'(bif.shiftout), 32'd0);
        aclr = 1'b0;
        bif.enable = 1'b1;
        tick();

        aset = 1'b1;
        #1;
        chk("aset_q", 32'(bif.q), 32'h01);
        @(negedge clock);
        aset = 1'b0;
        tick();

        // Logical left burst of 3 with shiftin=1
        do_load(8'hA5);
        chk("load_q", 32'(bif.q), 32'hA5);
        bif.dir = 1'b0; bif.mode = 2'b00; bif.shiftin = 1'b1;
        burst(4'd3, 99, 0, bc);
        chk("log_q", 32'(bif.q), 32'h2F);
        chk("log_so", 32'(bif.shiftout), 32'd1);
        chk("log_busy_cyc", 32'(bc), 32'd3);
        chk("log_busy_at_done", 32'(bif.busy), 32'd0);
        tick();
        chk("log_done_pulse", 32'(bif.done), 32'd0);

        // Rotate right by 1
        do_load(8'h81);
        bif.dir = 1'b1; bif.mode = 2'b01;
        burst(4'd1, 99, 0, bc);
        chk("rot_q", 32'(bif.q), 32'hC0);
        chk("rot_so", 32'(bif.shiftout), 32'd1);

        // Arithmetic right by 2
        do_load(8'h80);
        bif.dir = 1'b1; bif.mode = 2'b10;
        burst(4'd2, 99, 0, bc);
        chk("ari_q", 32'(bif.q), 32'hE0);
        chk("ari_so", 32'(bif.shiftout), 32'd0);

        // Stall two cycles mid-burst
        do_load(8'h01);
        bif.dir = 1'b0; bif.mode = 2'b00; bif.shiftin = 1'b0;
        burst(4'd3, 1, 2, bc);
        chk("stall_busy_cyc", 32'(bc), 32'd5);
        chk("stall_q", 32'(bif.q), 32'h08);

        // sclr aborts a burst, no done, shiftout holds
        do_load(8'hFF);
        bif.start = 1'b1; bif.count = 4'd5;
        tick();
        bif.start = 1'b0;
        tick();
        bif.sclr = 1'b1;
        tick();
        bif.sclr = 1'b0;
        chk("sclr_q", 32'(bif.q), 32'h00);
        chk("sclr_busy", 32'(bif.busy), 32'd0);
        chk("sclr_so", 32'(bif.shiftout), 32'd1);
        dcnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (bif.done) dcnt++;
            tick();
        end
        chk("sclr_no_done", 32'(dcnt), 32'd0);

        // Zero-length burst
        do_load(8'h5A);
        bif.start = 1'b1; bif.count = 4'd0;
        tick();
        bif.start = 1'b0;
        chk("cnt0_done", 32'(bif.done), 32'd1);
        chk("cnt0_busy", 32'(bif.busy), 32'd0);
        chk("cnt0_q", 32'(bif.q), 32'h5A);
        tick();
        chk("cnt0_done_pulse", 32'(bif.done), 32'd0);

        // start held during a burst must not restart it
        do_load(8'h01);
        bif.dir = 1'b0; bif.mode = 2'b00; bif.shiftin = 1'b0;
        bif.start = 1'b1; bif.count = 4'd2;
        tick();
        bif.count = 4'd7;
        tick();
        chk("sib_busy", 32'(bif.busy), 32'd1);
        tick();
        bif.start = 1'b0;
        chk("sib_done", 32'(bif.done), 32'd1);
        chk("sib_q", 32'(bif.q), 32'h04);
        tick();
        chk("sib_idle", 32'(bif.busy), 32'd0);

        // Maximum burst: 15 rotates right of 0x01
        do_load(8'h01);
        bif.dir = 1'b1; bif.mode = 2'b01;
        burst(4'd15, 99, 0, bc);
        chk("max_busy_cyc", 32'(bc), 32'd15);
        chk("max_q", 32'(bif.q), 32'h02);
        chk("max_so", 32'(bif.shiftout), 32'd0);

        // Single idle shift
        do_load(8'h03);
        bif.dir = 1'b1; bif.mode = 2'b00; bif.shiftin = 1'b0;
        bif.shift = 1'b1;
        tick();
        bif.shift = 1'b0;
        chk("one_q", 32'(bif.q), 32'h01);
        chk("one_so", 32'(bif.shiftout), 32'd1);
        chk("one_busy", 32'(bif.busy), 32'd0);
        chk("one_done", 32'(bif.done), 32'd0);

        // aclr mid-burst acts immediately
        do_load(8'hFF);
        bif.dir = 1'b0;
        bif.start = 1'b1; bif.count = 4'd5;
        tick();
        bif.start = 1'b0;
        tick();
        aclr = 1'b1;
        #1;
        chk("aclr_q", 32'(bif.q), 32'h00);
        chk("aclr_busy", 32'(bif.busy), 32'd0);
        chk("aclr_done", 32'(bif.done), 32'd0);
        chk("aclr_so", 32'(bif.shiftout), 32'd0);
        tick();
        aclr = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
